// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU/DMA) round-robin arbiter onto a single shared memory port.
// One transaction per grant, with a one-cycle RELEASE bubble and a BUSY timeout abort.
module mem_port_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_r_req,
  input  logic [31:0] m0_ar_addr,
  output logic [31:0] m0_r_data,
  output logic        m0_r_valid,
  input  logic        m0_w_req,
  input  logic [31:0] m0_aw_addr,
  input  logic [31:0] m0_w_data,
  output logic        m0_w_done,
  input  logic        m1_r_req,
  input  logic [31:0] m1_ar_addr,
  output logic [31:0] m1_r_data,
  output logic        m1_r_valid,
  input  logic        m1_w_req,
  input  logic [31:0] m1_aw_addr,
  input  logic [31:0] m1_w_data,
  output logic        m1_w_done,
  output logic        s_r_req,
  output logic        s_w_req,
  output logic [31:0] s_ar_addr,
  output logic [31:0] s_aw_addr,
  output logic [31:0] s_w_data,
  input  logic [31:0] s_r_data,
  input  logic        s_r_valid,
  input  logic        s_w_done,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_R  = 2'd1;
  localparam logic [1:0] BUSY_W  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]  state;
  logic        owner;
  logic        last_grant;
  logic [15:0] cnt;

  logic        pend0, pend1, sel, sel_r;
  logic        own_r, own_w, own_req, done, tmo, busy;
  logic [31:0] own_ar, own_aw, own_wd;
  logic        r_fwd, w_fwd;

  always_comb begin
    pend0   = m0_r_req | m0_w_req;
    pend1   = m1_r_req | m1_w_req;
    sel     = (pend0 && pend1) ? ~last_grant : pend1;
    sel_r   = sel ? m1_r_req : m0_r_req;
    own_r   = owner ? m1_r_req   : m0_r_req;
    own_w   = owner ? m1_w_req   : m0_w_req;
    own_ar  = owner ? m1_ar_addr : m0_ar_addr;
    own_aw  = owner ? m1_aw_addr : m0_aw_addr;
    own_wd  = owner ? m1_w_data  : m0_w_data;
    busy    = (state == BUSY_R) || (state == BUSY_W);
    own_req = (state == BUSY_R) ? own_r : own_w;
    done    = ((state == BUSY_R) && s_r_valid) || ((state == BUSY_W) && s_w_done);
    // Widened compare: abort on the BUSY cycle whose increment brings cnt to TIMEOUT.
    tmo     = ({1'b0, cnt} + 17'd1) >= {1'b0, TIMEOUT};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pend0 || pend1) begin
            owner <= sel;
            state <= sel_r ? BUSY_R : BUSY_W;
          end
        end
        BUSY_R, BUSY_W: begin
          if (!done && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
          if (done || !own_req) begin
            state      <= RELEASE;
            last_grant <= owner;
          end else if (tmo) begin
            state       <= RELEASE;
            last_grant  <= owner;
            timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completions are suppressed while rst is high so a reset edge never forwards one.
  always_comb begin
    grant     = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;
    s_r_req   = (state == BUSY_R) ? own_r  : 1'b0;
    s_ar_addr = (state == BUSY_R) ? own_ar : '0;
    s_w_req   = (state == BUSY_W) ? own_w  : 1'b0;
    s_aw_addr = (state == BUSY_W) ? own_aw : '0;
    s_w_data  = (state == BUSY_W) ? own_wd : '0;
    r_fwd      = (state == BUSY_R) && s_r_valid && !rst;
    w_fwd      = (state == BUSY_W) && s_w_done && !rst;
    m0_r_valid = r_fwd && !owner;
    m1_r_valid = r_fwd && owner;
    m0_r_data  = m0_r_valid ? s_r_data : '0;
    m1_r_data  = m1_r_valid ? s_r_data : '0;
    m0_w_done  = w_fwd && !owner;
    m1_w_done  = w_fwd && owner;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: completions are scoreboarded, grant/port
// routing, RELEASE bubble, round-robin, abort, timeout and reset behaviour are checked.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_r_req = 1'b0, m0_w_req = 1'b0, m1_r_req = 1'b0, m1_w_req = 1'b0;
  logic [31:0] m0_ar_addr = '0, m0_aw_addr = '0, m0_w_data = '0;
  logic [31:0] m1_ar_addr = '0, m1_aw_addr = '0, m1_w_data = '0;
  logic [31:0] m0_r_data, m1_r_data;
  logic        m0_r_valid, m1_r_valid, m0_w_done, m1_w_done;
  logic        s_r_req, s_w_req;
  logic [31:0] s_ar_addr, s_aw_addr, s_w_data;
  logic [31:0] s_r_data = '0;
  logic        s_r_valid = 1'b0, s_w_done = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  mem_port_arbiter #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .m0_r_req(m0_r_req), .m0_ar_addr(m0_ar_addr), .m0_r_data(m0_r_data), .m0_r_valid(m0_r_valid),
    .m0_w_req(m0_w_req), .m0_aw_addr(m0_aw_addr), .m0_w_data(m0_w_data), .m0_w_done(m0_w_done),
    .m1_r_req(m1_r_req), .m1_ar_addr(m1_ar_addr), .m1_r_data(m1_r_data), .m1_r_valid(m1_r_valid),
    .m1_w_req(m1_w_req), .m1_aw_addr(m1_aw_addr), .m1_w_data(m1_w_data), .m1_w_done(m1_w_done),
    .s_r_req(s_r_req), .s_w_req(s_w_req), .s_ar_addr(s_ar_addr), .s_aw_addr(s_aw_addr),
    .s_w_data(s_w_data), .s_r_data(s_r_data), .s_r_valid(s_r_valid), .s_w_done(s_w_done),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Completion codes: 0 = m0 read, 1 = m1 read, 2 = m0 write, 3 = m1 write.
  task automatic sb_pop(input logic [1:0] kind, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected", {kind, data}, 64'h3_FFFF_FFFF_F);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_completion", {kind, data}, e);
    end
  endtask

  always @(negedge clk) begin
    if (m0_r_valid) sb_pop(2'd0, m0_r_data);
    if (m1_r_valid) sb_pop(2'd1, m1_r_data);
    if (m0_w_done)  sb_pop(2'd2, 32'h0);
    if (m1_w_done)  sb_pop(2'd3, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (grant != 2'b00) return;
    end
    check_eq("grant_wait", {63'b0, grant != 2'b00}, 64'd1);
  endtask

  // Waits for the grant, answers after 'delay' BUSY cycles (>= 2), checks the bubble.
  task automatic serve(input logic wr, input logic m, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int unsigned delay, input logic keep);
    wait_grant();
    check_eq("grant", grant, m ? 2'b10 : 2'b01);
    if (wr) begin
      check_eq("s_w_req", s_w_req, 1);
      check_eq("s_aw_addr", s_aw_addr, addr);
      check_eq("s_w_data", s_w_data, wdata);
      check_eq("s_r_req_in_w", s_r_req, 0);
    end else begin
      check_eq("s_r_req", s_r_req, 1);
      check_eq("s_ar_addr", s_ar_addr, addr);
      check_eq("s_w_req_in_r", s_w_req, 0);
    end
    for (int unsigned i = 1; i < delay; i++) step();
    if (wr) begin
      s_w_done = 1'b1;
      exp_q.push_back({m ? 2'd3 : 2'd2, 32'h0});
    end else begin
      s_r_valid = 1'b1;
      s_r_data = rdata;
      exp_q.push_back({m ? 2'd1 : 2'd0, rdata});
    end
    @(negedge clk);
    if (wr) check_eq("other_w_done", m ? m0_w_done : m1_w_done, 0);
    else    check_eq("other_r_out", m ? {m0_r_valid, m0_r_data} : {m1_r_valid, m1_r_data}, 0);
    step();
    s_w_done = 1'b0;
    s_r_valid = 1'b0;
    s_r_data = '0;
    if (!keep) begin
      if (wr) begin if (m) m1_w_req = 1'b0; else m0_w_req = 1'b0; end
      else    begin if (m) m1_r_req = 1'b0; else m0_r_req = 1'b0; end
    end
    @(negedge clk);
    check_eq("release_grant", grant, 2'b00);
    check_eq("release_sreq", {s_r_req, s_w_req}, 2'b00);
  endtask

  initial begin
    int n;
    m0_ar_addr = 32'h0000_1000;
    m1_ar_addr = 32'h0000_3000;
    do_reset();
    @(negedge clk);
    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_terr", timeout_err, 0);
    check_eq("rst_sout", {s_r_req, s_w_req, s_ar_addr, s_aw_addr, s_w_data}, 0);
    check_eq("rst_mout", {m0_r_valid, m1_r_valid, m0_w_done, m1_w_done}, 0);

    // Single M0 read, data after 3 cycles.
    step();
    m0_r_req = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h1234_5678, 3, 1'b0);

    // Single M1 write.
    step();
    m1_aw_addr = 32'h2000_0040;
    m1_w_data = 32'hA5A5_A5A5;
    m1_w_req = 1'b1;
    serve(1'b1, 1'b1, 32'h2000_0040, 32'hA5A5_A5A5, 32'h0, 2, 1'b0);

    // Simultaneous requests after reset: alternate 01,10,01,10.
    do_reset();
    m0_r_req = 1'b1;
    m1_r_req = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0A01, 2, 1'b1);
    serve(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0B02, 3, 1'b1);
    serve(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0A03, 2, 1'b0);
    serve(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0B04, 2, 1'b0);

    // M1 read and write held together: read first.
    step();
    m1_aw_addr = 32'h4000_0008;
    m1_w_data = 32'h0BAD_F00D;
    m1_r_req = 1'b1;
    m1_w_req = 1'b1;
    serve(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'hCAFE_0001, 2, 1'b0);
    serve(1'b1, 1'b1, 32'h4000_0008, 32'h0BAD_F00D, 32'h0, 2, 1'b0);

    // Owner drops its request mid-BUSY: abort, then the other side wins the tie.
    do_reset();
    m0_r_req = 1'b1;
    wait_grant();
    check_eq("abort_grant", grant, 2'b01);
    step();
    m0_r_req = 1'b0;
    @(negedge clk);
    check_eq("abort_sreq_follow", s_r_req, 0);
    @(negedge clk);
    check_eq("abort_release", grant, 2'b00);
    step();
    m0_r_req = 1'b1;
    m1_r_req = 1'b1;
    serve(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0C01, 2, 1'b0);
    serve(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0C02, 2, 1'b0);

    // Completion on the last permitted BUSY cycle beats the timeout.
    do_reset();
    m0_r_req = 1'b1;
    serve(1'b0, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0D08, 8, 1'b0);
    check_eq("edge_no_terr", timeout_err, 0);

    // Timeout: no response, abort after 8 BUSY cycles, then M1 served.
    do_reset();
    m0_r_req = 1'b1;
    m1_r_req = 1'b1;
    wait_grant();
    check_eq("tmo_grant", grant, 2'b01);
    check_eq("tmo_err_clear", timeout_err, 0);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant != 2'b01) break;
      n++;
    end
    check_eq("tmo_busy_cycles", n, 8);
    check_eq("tmo_release", grant, 2'b00);
    check_eq("tmo_err_set", timeout_err, 1);
    step();
    m0_r_req = 1'b0;
    serve(1'b0, 1'b1, 32'h0000_3000, 32'h0, 32'h0000_0E01, 2, 1'b0);
    check_eq("tmo_err_sticky", timeout_err, 1);

    // Reset during BUSY_W with s_w_done high.
    step();
    m0_aw_addr = 32'h5000_0000;
    m0_w_data = 32'h1111_2222;
    m0_w_req = 1'b1;
    wait_grant();
    check_eq("rstw_grant", grant, 2'b01);
    step();
    s_w_done = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstw_no_done", m0_w_done, 0);
    step();
    rst = 1'b0;
    s_w_done = 1'b0;
    m0_w_req = 1'b0;
    @(negedge clk);
    check_eq("rstw_grant_drop", grant, 2'b00);
    check_eq("rstw_terr_clr", timeout_err, 0);

    step();
    check_eq("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd1023: maximum BUSY cycles before a transaction is aborted.
REQ-002 clk  in  1  single clock; every flop is on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mX_r_req  in  1  read request from requester X (X=0 CPU, X=1 DMA); held until completion.
REQ-005 mX_ar_addr  in  32  read address from requester X.
REQ-006 mX_r_data  out  32  read data to requester X.
REQ-007 mX_r_valid  out  1  one-cycle read completion to requester X.
REQ-008 mX_w_req  in  1  write request from requester X; held until completion.
REQ-009 mX_aw_addr  in  32  write address from requester X.
REQ-010 mX_w_data  in  32  write data from requester X.
REQ-011 mX_w_done  out  1  one-cycle write completion to requester X.
REQ-012 s_r_req, s_w_req  out  1 each  shared-port requests.
REQ-013 s_ar_addr, s_aw_addr, s_w_data  out  32 each  shared-port address and data.
REQ-014 s_r_data  in  32  read data; qualified by s_r_valid  in  1.
REQ-015 s_w_done  in  1  write completion.
REQ-016 grant  out  2  one-hot owner (bit0 = M0, bit1 = M1); 2'b00 means no owner.
REQ-017 timeout_err  out  1  sticky abort flag.

Function
REQ-018 FSM states: IDLE, BUSY_R, BUSY_W, RELEASE; state, owner, last_grant and the timeout counter are registered.
REQ-019 IDLE: any mX_r_req or mX_w_req pending -> select owner, register it, and go to BUSY_R or BUSY_W the next cycle; no pending request -> stay in IDLE.
REQ-020 Selection is round-robin: if both requesters are pending, the one not equal to last_grant wins; if only one is pending, it wins.
REQ-021 If the owner has both r_req and w_req pending, read goes first (BUSY_R); the write is arbitrated again later.
REQ-022 Latency: a request sampled in IDLE at edge n -> s_*_req asserted in cycle n+1; grant is valid in the same cycle.
REQ-023 In BUSY_R, s_r_req = owner r_req and s_ar_addr = owner address; s_w_req = 0.
REQ-024 In BUSY_W, s_w_req = owner w_req, and s_aw_addr and s_w_data come from the owner; s_r_req = 0.
REQ-025 Outside BUSY, all s_* outputs are 0.
REQ-026 s_r_valid in BUSY_R is forwarded combinationally to the owner's r_valid, with r_data = s_r_data; the non-owner always sees r_valid = 0 and r_data = 0.
REQ-027 s_w_done in BUSY_W is forwarded the same way to the owner's w_done.
REQ-028 Completion of the owned transaction -> RELEASE and last_grant <= owner.
REQ-029 Completion signals arriving in IDLE or RELEASE are ignored.
REQ-030 RELEASE lasts exactly one cycle with grant = 2'b00 and s_*_req = 0, then returns to IDLE; back-to-back transactions therefore have a one-cycle bubble.
REQ-031 If the owner drops its req in BUSY before completion -> abort to RELEASE, forward no completion, and update last_grant.
REQ-032 Timeout counter: 16-bit, cleared on entry to BUSY, incremented each BUSY cycle without completion.
REQ-033 When the counter reaches TIMEOUT -> abort to RELEASE, set timeout_err = 1, forward no completion.
REQ-034 timeout_err stays set until reset.
REQ-035 Counter saturates and does not wrap.
REQ-036 Completion and timeout in the same cycle -> completion wins and timeout_err is not set.

Reset
REQ-037 rst = 1 at an edge -> state = IDLE, grant = 2'b00, last_grant = M1 (so M0 wins the first tie), counter = 0, timeout_err = 0.
REQ-038 Combinational outputs (s_*, mX_r_valid, mX_w_done) = 0 while in IDLE after reset.
REQ-039 Reset mid-transaction drops the grant at that edge; a completion arriving in the same cycle is not forwarded.

Verification
REQ-040 M0 read addr 0x0000_1000 alone, memory returns 0x1234_5678 after 3 cycles -> s_r_req in cycle n+1, m0_r_valid one cycle with 0x1234_5678, m1_r_valid = 0, one RELEASE cycle.
REQ-041 M0 and M1 both request in the same cycle after reset -> M0 served first, then M1; repeat with both held -> grant alternates 01,10,01.
REQ-042 M1 write addr 0x2000_0040, data 0xA5A5_A5A5 -> s_aw_addr and s_w_data match, m1_w_done pulses once when s_w_done = 1.
REQ-043 M0 read with s_r_valid never asserted, TIMEOUT = 8 -> abort after 8 BUSY cycles, timeout_err = 1 and stays set, M1 served next.
REQ-044 M1 holds r_req and w_req together -> read completes first, then write after RELEASE and IDLE.
REQ-045 rst pulsed during BUSY_W while s_w_done = 1 -> no w_done forwarded, grant = 2'b00 the next cycle.
